// File: rtl/imem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for a single in-order memory port with response routing.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration (default: fixed priority, D over F).
module imem_port_arbiter #(
  parameter int MAX_OUTST = 8,
  parameter int AW        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         f_req_valid,
  output logic                         f_req_ready,
  input  logic [AW-1:0]                f_req_addr,
  output logic                         f_resp_valid,
  input  logic                         f_resp_ready,
  output logic [31:0]                  f_resp_data,
  input  logic                         d_req_valid,
  output logic                         d_req_ready,
  input  logic [AW-1:0]                d_req_addr,
  input  logic                         d_req_we,
  input  logic [31:0]                  d_req_wdata,
  input  logic [3:0]                   d_req_wstrb,
  output logic                         d_resp_valid,
  input  logic                         d_resp_ready,
  output logic [31:0]                  d_resp_data,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [AW-1:0]                mem_req_addr,
  output logic                         mem_req_we,
  output logic [31:0]                  mem_req_wdata,
  output logic [3:0]                   mem_req_wstrb,
  input  logic                         mem_resp_valid,
  output logic                         mem_resp_ready,
  input  logic [31:0]                  mem_resp_data,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         orphan_err
);

  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  localparam logic SRC_F = 1'b0;
  localparam logic SRC_D = 1'b1;

  logic [MAX_OUTST-1:0] id_fifo;
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;
  logic                 orphan_q;
  logic                 sel;
  logic                 hd;
  logic                 can_issue;
  logic                 has_outst;
  logic                 grant_fire;
  logic                 pop_fire;

  assign can_issue  = (count < CW'(MAX_OUTST));
  assign has_outst  = (count != '0);
  assign hd         = id_fifo[head];
  assign grant_fire = mem_req_valid & mem_req_ready;
  assign pop_fire   = has_outst & mem_resp_valid & mem_resp_ready;

`ifdef MEM_ARB_RR_EN
  // last_sel holds the source of the most recent grant; the other side wins a tie.
  logic last_sel;

  always_comb begin
    sel = SRC_F;
    if (f_req_valid && d_req_valid) sel = ~last_sel;
    else if (d_req_valid)           sel = SRC_D;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             last_sel <= SRC_F;
    else if (grant_fire) last_sel <= sel;
  end
`else
  always_comb begin
    sel = d_req_valid ? SRC_D : SRC_F;
  end
`endif

  // Request path: purely combinational mux onto the memory port.
  always_comb begin
    mem_req_valid = can_issue & (f_req_valid | d_req_valid);
    f_req_ready   = can_issue & mem_req_ready & f_req_valid & (sel == SRC_F);
    d_req_ready   = can_issue & mem_req_ready & d_req_valid & (sel == SRC_D);
    mem_req_addr  = f_req_addr;
    mem_req_we    = 1'b0;
    mem_req_wdata = '0;
    mem_req_wstrb = '0;
    if (sel == SRC_D) begin
      mem_req_addr  = d_req_addr;
      mem_req_we    = d_req_we;
      mem_req_wdata = d_req_wdata;
      mem_req_wstrb = d_req_wstrb;
    end
  end

  // Response path: the FIFO head names the owner; with nothing outstanding the response is sunk.
  always_comb begin
    f_resp_valid   = has_outst & mem_resp_valid & (hd == SRC_F);
    d_resp_valid   = has_outst & mem_resp_valid & (hd == SRC_D);
    f_resp_data    = mem_resp_data;
    d_resp_data    = mem_resp_data;
    mem_resp_ready = mem_resp_valid;
    if (has_outst) mem_resp_ready = (hd == SRC_D) ? d_resp_ready : f_resp_ready;
  end

  always_ff @(posedge clk) begin
    if (grant_fire) id_fifo[tail] <= sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      orphan_q <= 1'b0;
    end else begin
      if (grant_fire) tail <= tail + 1'b1;
      if (pop_fire)   head <= head + 1'b1;
      case ({grant_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!has_outst && mem_resp_valid) orphan_q <= 1'b1;
    end
  end

  assign outst_cnt  = count;
  assign orphan_err = orphan_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed testbench for imem_port_arbiter; expectations follow the MEM_ARB_RR_EN build setting.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req_valid, f_req_ready;
  logic [31:0] f_req_addr;
  logic        f_resp_valid, f_resp_ready;
  logic [31:0] f_resp_data;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_we;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wstrb;
  logic        d_resp_valid, d_resp_ready;
  logic [31:0] d_resp_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic [3:0]  outst_cnt;
  logic        orphan_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.MAX_OUTST(8), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_resp_valid(f_resp_valid), .f_resp_ready(f_resp_ready), .f_resp_data(f_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
    .outst_cnt(outst_cnt), .orphan_err(orphan_err)
  );

  task automatic idle();
    f_req_valid = 0; f_req_addr = '0; f_resp_ready = 0;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_wstrb = '0;
    d_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  // Inputs change right after a falling edge; outputs are observed 1 time unit later.
  task automatic test_reset();
    idle();
    @(negedge clk); #1;
    n_checks++; if (outst_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", outst_cnt); end
    n_checks++; if (orphan_err !== 1'b0) begin n_fail++; $display("FAIL reset_orphan got %b want 0", orphan_err); end
    n_checks++; if ({mem_req_valid, f_req_ready, d_req_ready, f_resp_valid, d_resp_valid, mem_resp_ready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_handshakes got %b want 000000",
        {mem_req_valid, f_req_ready, d_req_ready, f_resp_valid, d_resp_valid, mem_resp_ready}); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_fetch_reads();
    logic [31:0] rd [3];
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
    mem_req_ready = 1; f_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      f_req_addr = 32'(i * 4);
      #1;
      n_checks++; if (f_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin n_fail++; $display("FAIL f_rd_ready%0d got f=%b d=%b want f=1 d=0", i, f_req_ready, d_req_ready); end
      n_checks++; if (mem_req_addr !== 32'(i * 4) || mem_req_we !== 1'b0 || mem_req_wstrb !== 4'h0) begin
        n_fail++; $display("FAIL f_rd_req%0d got addr=%h we=%b strb=%h want addr=%h we=0 strb=0", i, mem_req_addr, mem_req_we, mem_req_wstrb, i * 4); end
      @(negedge clk);
    end
    f_req_valid = 0; mem_req_ready = 0;
    #1;
    n_checks++; if (outst_cnt !== 4'd3) begin n_fail++; $display("FAIL f_rd_cnt3 got %0d want 3", outst_cnt); end
    @(negedge clk);
    f_resp_ready = 1; mem_resp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      mem_resp_data = rd[i];
      #1;
      n_checks++; if (f_resp_valid !== 1'b1 || f_resp_data !== rd[i]) begin n_fail++; $display("FAIL f_rd_resp%0d got v=%b data=%h want v=1 data=%h", i, f_resp_valid, f_resp_data, rd[i]); end
      n_checks++; if (d_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin n_fail++; $display("FAIL f_rd_route%0d got dv=%b mrdy=%b want dv=0 mrdy=1", i, d_resp_valid, mem_resp_ready); end
      @(negedge clk);
    end
    idle();
    #1;
    n_checks++; if (outst_cnt !== 4'd0) begin n_fail++; $display("FAIL f_rd_cnt0 got %0d want 0", outst_cnt); end
    n_checks++; if (orphan_err !== 1'b0) begin n_fail++; $display("FAIL f_rd_orphan got %b want 0", orphan_err); end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [3:0] pat;  // bit i set: D expected to win cycle i
`ifdef MEM_ARB_RR_EN
    pat = 4'b0101;
`else
    pat = 4'b1111;
`endif
    mem_req_ready = 1;
    f_req_valid = 1; f_req_addr = 32'h40;
    d_req_valid = 1; d_req_addr = 32'h80;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (d_req_ready !== pat[i] || f_req_ready !== ~pat[i]) begin
        n_fail++; $display("FAIL arb_grant%0d got f=%b d=%b want f=%b d=%b", i, f_req_ready, d_req_ready, ~pat[i], pat[i]); end
      n_checks++; if (mem_req_addr !== (pat[i] ? 32'h80 : 32'h40)) begin
        n_fail++; $display("FAIL arb_addr%0d got %h want %h", i, mem_req_addr, pat[i] ? 32'h80 : 32'h40); end
      @(negedge clk);
    end
    idle();
    #1;
    n_checks++; if (outst_cnt !== 4'd4) begin n_fail++; $display("FAIL arb_cnt4 got %0d want 4", outst_cnt); end
    @(negedge clk);
    f_resp_ready = 1; d_resp_ready = 1; mem_resp_valid = 1;
    for (int i = 0; i < 4; i++) begin
      mem_resp_data = 32'hA0 + 32'(i);
      #1;
      n_checks++; if (d_resp_valid !== pat[i] || f_resp_valid !== ~pat[i]) begin
        n_fail++; $display("FAIL arb_route%0d got f=%b d=%b want f=%b d=%b", i, f_resp_valid, d_resp_valid, ~pat[i], pat[i]); end
      @(negedge clk);
    end
    idle();
    #1;
    n_checks++; if (outst_cnt !== 4'd0) begin n_fail++; $display("FAIL arb_drain got %0d want 0", outst_cnt); end
    @(negedge clk);
  endtask

  task automatic test_full_fifo();
    mem_req_ready = 1; f_req_valid = 1; f_req_addr = 32'h1000;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if (f_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d got ready=%b want 1", i, f_req_ready); end
      @(negedge clk);
    end
    #1;
    n_checks++; if (outst_cnt !== 4'd8) begin n_fail++; $display("FAIL full_cnt8 got %0d want 8", outst_cnt); end
    n_checks++; if (mem_req_valid !== 1'b0 || f_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_block got mv=%b fr=%b want 0 0", mem_req_valid, f_req_ready); end
    @(negedge clk);
    // Pop while full: the slot freed this cycle is not reusable until the next one.
    mem_resp_valid = 1; f_resp_ready = 1;
    #1;
    n_checks++; if (mem_req_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin n_fail++; $display("FAIL full_nobypass got mv=%b mrr=%b want 0 1", mem_req_valid, mem_resp_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (outst_cnt !== 4'd7) begin n_fail++; $display("FAIL full_cnt7 got %0d want 7", outst_cnt); end
    n_checks++; if (mem_req_valid !== 1'b1 || f_req_ready !== 1'b1) begin n_fail++; $display("FAIL full_resume got mv=%b fr=%b want 1 1", mem_req_valid, f_req_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (outst_cnt !== 4'd7) begin n_fail++; $display("FAIL full_pushpop got %0d want 7", outst_cnt); end
    f_req_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 7; i++) @(negedge clk);
    idle();
    #1;
    n_checks++; if (outst_cnt !== 4'd0) begin n_fail++; $display("FAIL full_drain got %0d want 0", outst_cnt); end
    @(negedge clk);
  endtask

  task automatic test_resp_backpressure();
    mem_req_ready = 1; f_req_valid = 1; f_req_addr = 32'h200;
    #1;
    n_checks++; if (f_req_ready !== 1'b1 || mem_req_we !== 1'b0 || mem_req_wdata !== 32'h0) begin
      n_fail++; $display("FAIL bp_fgrant got fr=%b we=%b wd=%h want 1 0 0", f_req_ready, mem_req_we, mem_req_wdata); end
    @(negedge clk);
    f_req_valid = 0;
    d_req_valid = 1; d_req_addr = 32'h100; d_req_we = 1; d_req_wdata = 32'hDEADBEEF; d_req_wstrb = 4'hF;
    #1;
    n_checks++; if (d_req_ready !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_we !== 1'b1 ||
                    mem_req_wdata !== 32'hDEADBEEF || mem_req_wstrb !== 4'hF) begin
      n_fail++; $display("FAIL bp_dwrite got dr=%b a=%h we=%b wd=%h s=%h want 1 100 1 deadbeef f",
        d_req_ready, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wstrb); end
    @(negedge clk);
    idle();
    mem_resp_valid = 1; mem_resp_data = 32'hAAAA; f_resp_ready = 1; d_resp_ready = 0;
    #1;
    n_checks++; if (f_resp_valid !== 1'b1 || f_resp_data !== 32'hAAAA || mem_resp_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_fresp got fv=%b fd=%h mrr=%b want 1 aaaa 1", f_resp_valid, f_resp_data, mem_resp_ready); end
    @(negedge clk);
    mem_resp_data = 32'hBBBB;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (d_resp_valid !== 1'b1 || mem_resp_ready !== 1'b0 || outst_cnt !== 4'd1) begin
        n_fail++; $display("FAIL bp_stall%0d got dv=%b mrr=%b cnt=%0d want 1 0 1", i, d_resp_valid, mem_resp_ready, outst_cnt); end
      @(negedge clk);
    end
    d_resp_ready = 1;
    #1;
    n_checks++; if (mem_resp_ready !== 1'b1 || d_resp_data !== 32'hBBBB) begin
      n_fail++; $display("FAIL bp_release got mrr=%b dd=%h want 1 bbbb", mem_resp_ready, d_resp_data); end
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (outst_cnt !== 4'd0) begin n_fail++; $display("FAIL bp_cnt0 got %0d want 0", outst_cnt); end
    @(negedge clk);
  endtask

  task automatic test_orphan();
    mem_resp_valid = 1; mem_resp_data = 32'h77;
    #1;
    n_checks++; if (mem_resp_ready !== 1'b1 || f_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL orph_sink got mrr=%b fv=%b dv=%b want 1 0 0", mem_resp_ready, f_resp_valid, d_resp_valid); end
    @(negedge clk);
    idle();
    @(negedge clk); @(negedge clk);
    #1;
    n_checks++; if (orphan_err !== 1'b1 || outst_cnt !== 4'd0) begin
      n_fail++; $display("FAIL orph_sticky got err=%b cnt=%0d want 1 0", orphan_err, outst_cnt); end
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++; if (orphan_err !== 1'b0) begin n_fail++; $display("FAIL orph_clear got %b want 0", orphan_err); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mem_req_ready = 1; f_req_valid = 1; f_req_addr = 32'h300;
    for (int i = 0; i < 3; i++) @(negedge clk);
    idle();
    #1;
    n_checks++; if (outst_cnt !== 4'd3) begin n_fail++; $display("FAIL rmid_cnt3 got %0d want 3", outst_cnt); end
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++; if (outst_cnt !== 4'd0 || {mem_req_valid, f_resp_valid, d_resp_valid, mem_resp_ready} !== 4'b0) begin
      n_fail++; $display("FAIL rmid_clear got cnt=%0d v=%b want 0 0000", outst_cnt,
        {mem_req_valid, f_resp_valid, d_resp_valid, mem_resp_ready}); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    mem_req_ready = 1; f_req_valid = 1; f_req_addr = 32'h400;
    #1;
    n_checks++; if (f_req_ready !== 1'b1 || mem_req_addr !== 32'h400) begin
      n_fail++; $display("FAIL rmid_req got fr=%b a=%h want 1 400", f_req_ready, mem_req_addr); end
    @(negedge clk);
    idle();
    mem_resp_valid = 1; mem_resp_data = 32'h55; f_resp_ready = 1;
    #1;
    n_checks++; if (f_resp_valid !== 1'b1 || f_resp_data !== 32'h55 || orphan_err !== 1'b0) begin
      n_fail++; $display("FAIL rmid_resp got fv=%b fd=%h err=%b want 1 55 0", f_resp_valid, f_resp_data, orphan_err); end
    @(negedge clk);
    idle();
    #1;
    n_checks++; if (outst_cnt !== 4'd0) begin n_fail++; $display("FAIL rmid_cnt0 got %0d want 0", outst_cnt); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_reads();
    test_arbitration();
    test_full_fifo();
    test_resp_backpressure();
    test_orphan();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
